vex_issue_sched: RTL and testbench



---
 rtl/cellrv32_package.sv | 35 +++
 rtl/vex_wb_resv.sv | 80 ++++++++
 rtl/vex_issue_sched.sv | 170 +++++++++++++++++
 tb/tb_vex_issue_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cellrv32_package.sv
// rtl/cellrv32_package.sv - shared types and latency helpers for the vector issue scheduler
//
// Purpose: latency-class enum, reservation-line entry type, default
// latencies and the class-to-latency lookup used by vex_issue_sched and
// vex_wb_resv.
package cellrv32_package;

   typedef enum logic [1:0] {
      VEX_LAT_INT    = 2'd0,
      VEX_LAT_MULDIV = 2'd1,
      VEX_LAT_RDC    = 2'd2,
      VEX_LAT_FP     = 2'd3
   } vex_lat_class_e;

   typedef struct packed {
      logic       v;
      logic [4:0] dst;
   } vex_resv_entry_t;

   localparam int unsigned VEX_INT_LAT_DEF    = 1;
   localparam int unsigned VEX_MULDIV_LAT_DEF = 5;
   localparam int unsigned VEX_RDC_LAT_DEF    = 5;

   // FP never loads the reservation line, so it shares the INT value here.
   function automatic int unsigned vex_lat_of(input vex_lat_class_e cls,
                                              input int unsigned    muldiv_lat,
                                              input int unsigned    rdc_lat);
      case (cls)
         VEX_LAT_MULDIV: return muldiv_lat;
         VEX_LAT_RDC:    return rdc_lat;
         default:        return VEX_INT_LAT_DEF;
      endcase
   endfunction

endpackage

// File: rtl/vex_wb_resv.sv
// rtl/vex_wb_resv.sv - writeback-port reservation shift line
//
// Purpose: one {v, dst} slot per future cycle. Slot 0 is the entry writing
// back this cycle; every clock the line shifts down by one. A fixed-latency
// op issued now with latency L is placed in slot L-1 after the shift, so it
// reaches slot 0 exactly L cycles after issue.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load_i         fixed-latency op issues this cycle
//   class_i        latency class of the offered op
//   dst_i          destination register of the offered op
//   conflict_o     slot L of the offered class is already taken
//   empty_o        no slot holds a valid entry
//   retire_v_o     slot 0 valid (register-file write this cycle)
//   retire_dst_o   slot 0 destination
module vex_wb_resv
   import cellrv32_package::*;
#(
   parameter int unsigned MULDIV_LAT = VEX_MULDIV_LAT_DEF,
   parameter int unsigned RDC_LAT    = VEX_RDC_LAT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [1:0] class_i,
   input  logic [4:0] dst_i,
   output logic       conflict_o,
   output logic       empty_o,
   output logic       retire_v_o,
   output logic [4:0] retire_dst_o
);

   localparam int unsigned LMAX_ML = (MULDIV_LAT > RDC_LAT) ? MULDIV_LAT : RDC_LAT;
   localparam int unsigned LMAX    = (LMAX_ML > VEX_INT_LAT_DEF) ? LMAX_ML : VEX_INT_LAT_DEF;

   vex_resv_entry_t resv_q [LMAX];
   vex_resv_entry_t resv_d [LMAX];
   int unsigned     lat;

   always_comb begin
      lat = vex_lat_of(vex_lat_class_e'(class_i), MULDIV_LAT, RDC_LAT);

      for (int unsigned k = 0; k + 1 < LMAX; k++) begin
         resv_d[k] = resv_q[k+1];
      end
      resv_d[LMAX-1] = '0;

      // Slot lat-1 after the shift came from slot lat, which the conflict
      // check has already proven empty.
      for (int unsigned k = 0; k < LMAX; k++) begin
         if (load_i && (k + 1 == lat)) begin
            resv_d[k] = '{v: 1'b1, dst: dst_i};
         end
      end

      conflict_o = 1'b0;
      empty_o    = 1'b1;
      for (int unsigned k = 0; k < LMAX; k++) begin
         if ((k == lat) && resv_q[k].v) begin
            conflict_o = 1'b1;
         end
         if (resv_q[k].v) begin
            empty_o = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resv_q <= '{default: '0};
      end else begin
         resv_q <= resv_d;
      end
   end

   assign retire_v_o   = resv_q[0].v;
   assign retire_dst_o = resv_q[0].dst;

endmodule

// File: rtl/vex_issue_sched.sv
// rtl/vex_issue_sched.sv - vector issue scheduler and writeback-port controller
//
// Purpose: gates micro-ops into vex only when the single register-file write
// port is free at the op's writeback cycle, serialises variable-latency FP
// ops, and drives the register-file writeback address/valid.
// Optional feature: define VEX_SCHED_RAW_CHECK_EN to also block issue on
// RAW/WAW hazards against the busy bitmap.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid_i / in_ready_o     micro-op offer / accept
//   in_class_i                  0 INT, 1 MULDIV, 2 RDC, 3 FP
//   in_dst_i, in_src1_i/2_i     destination and source registers
//   in_src_use_i                {src2 used, src1 used}
//   vex_ready_i, vex_idle_i     vex can accept / vex pipeline empty
//   fp_done_i                   in-flight FP op writes back this cycle
//   vex_valid_o                 issue strobe to vex
//   wb_valid_o, wb_dst_o        register-file write this cycle
//   busy_o                      registers with pending writes
//   stall_cnt_o                 saturating count of stalled offer cycles
module vex_issue_sched
   import cellrv32_package::*;
#(
   parameter int unsigned VECTOR_REGISTERS = 32,
   parameter int unsigned MULDIV_LAT       = VEX_MULDIV_LAT_DEF,
   parameter int unsigned RDC_LAT          = VEX_RDC_LAT_DEF
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid_i,
   output logic                                in_ready_o,
   input  logic [1:0]                          in_class_i,
   input  logic [$clog2(VECTOR_REGISTERS)-1:0] in_dst_i,
   input  logic [$clog2(VECTOR_REGISTERS)-1:0] in_src1_i,
   input  logic [$clog2(VECTOR_REGISTERS)-1:0] in_src2_i,
   input  logic [1:0]                          in_src_use_i,
   input  logic                                vex_ready_i,
   input  logic                                vex_idle_i,
   input  logic                                fp_done_i,
   output logic                                vex_valid_o,
   output logic                                wb_valid_o,
   output logic [$clog2(VECTOR_REGISTERS)-1:0] wb_dst_o,
   output logic [VECTOR_REGISTERS-1:0]         busy_o,
   output logic [31:0]                         stall_cnt_o
);

   localparam int unsigned AW = $clog2(VECTOR_REGISTERS);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_FP_DRAIN = 2'd1;
   localparam logic [1:0] ST_FP_WAIT  = 2'd2;

   logic [1:0]                  state_q, state_d;
   logic [AW-1:0]               fp_dst_q, fp_dst_d;
   logic [VECTOR_REGISTERS-1:0] busy_q, busy_d;
   logic [31:0]                 stall_cnt_q, stall_cnt_d;

   logic       issue_ok;
   logic       issue;
   logic       is_fp;
   logic       raw_block;
   logic       resv_conflict;
   logic       resv_empty;
   logic       retire_v;
   logic [4:0] retire_dst;

   assign is_fp = (vex_lat_class_e'(in_class_i) == VEX_LAT_FP);

`ifdef VEX_SCHED_RAW_CHECK_EN
   assign raw_block = (busy_q[in_src1_i] & in_src_use_i[0])
                    | (busy_q[in_src2_i] & in_src_use_i[1])
                    |  busy_q[in_dst_i];
`else
   // Hazard freedom is upstream's job in this build; sources are ignored.
   logic unused_raw_inputs;
   assign unused_raw_inputs = ^{in_src1_i, in_src2_i, in_src_use_i};
   assign raw_block = 1'b0;
`endif

   vex_wb_resv #(
      .MULDIV_LAT (MULDIV_LAT),
      .RDC_LAT    (RDC_LAT)
   ) u_resv (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (issue && (state_q == ST_RUN)),
      .class_i      (in_class_i),
      .dst_i        (5'(in_dst_i)),
      .conflict_o   (resv_conflict),
      .empty_o      (resv_empty),
      .retire_v_o   (retire_v),
      .retire_dst_o (retire_dst)
   );

   always_comb begin
      issue_ok = 1'b0;
      case (state_q)
         ST_RUN:      issue_ok = !is_fp && vex_ready_i && !resv_conflict && !raw_block;
         ST_FP_DRAIN: issue_ok = vex_idle_i && resv_empty;
         default:     issue_ok = 1'b0;
      endcase
   end

   assign issue       = in_valid_i && issue_ok;
   assign in_ready_o  = issue;
   assign vex_valid_o = issue;

   // Only the FP op occupies the port in FP_WAIT; the line is empty then.
   always_comb begin
      if (state_q == ST_FP_WAIT) begin
         wb_valid_o = fp_done_i;
         wb_dst_o   = fp_dst_q;
      end else begin
         wb_valid_o = retire_v;
         wb_dst_o   = AW'(retire_dst);
      end
   end

   always_comb begin
      state_d  = state_q;
      fp_dst_d = fp_dst_q;
      case (state_q)
         ST_RUN: begin
            if (in_valid_i && is_fp) state_d = ST_FP_DRAIN;
         end
         ST_FP_DRAIN: begin
            if (issue) begin
               state_d  = ST_FP_WAIT;
               fp_dst_d = in_dst_i;
            end
         end
         ST_FP_WAIT: begin
            if (fp_done_i) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Clear before set so a same-cycle set on the same register wins.
   always_comb begin
      busy_d = busy_q;
      if (wb_valid_o) busy_d[wb_dst_o] = 1'b0;
      if (issue)      busy_d[in_dst_i] = 1'b1;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (in_valid_i && !in_ready_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         fp_dst_q    <= '0;
         busy_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         fp_dst_q    <= fp_dst_d;
         busy_q      <= busy_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign busy_o      = busy_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_vex_issue_sched.sv
// tb/tb_vex_issue_sched.sv - directed self-checking bench for vex_issue_sched
module tb_vex_issue_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [1:0]  in_class_i;
   logic [4:0]  in_dst_i;
   logic [4:0]  in_src1_i;
   logic [4:0]  in_src2_i;
   logic [1:0]  in_src_use_i;
   logic        vex_ready_i;
   logic        vex_idle_i;
   logic        fp_done_i;
   logic        vex_valid_o;
   logic        wb_valid_o;
   logic [4:0]  wb_dst_o;
   logic [31:0] busy_o;
   logic [31:0] stall_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

`ifdef VEX_SCHED_RAW_CHECK_EN
   localparam int RAW_ISSUE_CYCLE = 6;
`else
   localparam int RAW_ISSUE_CYCLE = 1;
`endif

   always #5 clk = ~clk;

   vex_issue_sched #(
      .VECTOR_REGISTERS (32),
      .MULDIV_LAT       (5),
      .RDC_LAT          (5)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .in_class_i   (in_class_i),
      .in_dst_i     (in_dst_i),
      .in_src1_i    (in_src1_i),
      .in_src2_i    (in_src2_i),
      .in_src_use_i (in_src_use_i),
      .vex_ready_i  (vex_ready_i),
      .vex_idle_i   (vex_idle_i),
      .fp_done_i    (fp_done_i),
      .vex_valid_o  (vex_valid_o),
      .wb_valid_o   (wb_valid_o),
      .wb_dst_o     (wb_dst_o),
      .busy_o       (busy_o),
      .stall_cnt_o  (stall_cnt_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic offer(input logic [1:0] cls, input logic [4:0] dst);
      in_valid_i = 1'b1;
      in_class_i = cls;
      in_dst_i   = dst;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      in_valid_i   = 1'b0;
      in_class_i   = 2'd0;
      in_dst_i     = '0;
      in_src1_i    = '0;
      in_src2_i    = '0;
      in_src_use_i = 2'b00;
      vex_ready_i  = 1'b1;
      vex_idle_i   = 1'b0;
      fp_done_i    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset state
      do_reset();
      settle();
      check("rst_busy",      busy_o,      32'h0);
      check("rst_wb_valid",  wb_valid_o,  1'b0);
      check("rst_wb_dst",    wb_dst_o,    5'd0);
      check("rst_stall",     stall_cnt_o, 32'h0);
      check("rst_ready",     in_ready_o,  1'b0);
      check("rst_vex_valid", vex_valid_o, 1'b0);

      // INT stream: dst 1,2,3 back to back
      offer(2'd0, 5'd1); settle();
      check("int_c0_ready", in_ready_o, 1'b1);
      check("int_c0_vexv",  vex_valid_o, 1'b1);
      step(); offer(2'd0, 5'd2); settle();
      check("int_c1_ready", in_ready_o, 1'b1);
      check("int_c1_wbv",   wb_valid_o, 1'b1);
      check("int_c1_wbd",   wb_dst_o,   5'd1);
      step(); offer(2'd0, 5'd3); settle();
      check("int_c2_ready", in_ready_o, 1'b1);
      check("int_c2_wbd",   wb_dst_o,   5'd2);
      step(); in_valid_i = 1'b0; settle();
      check("int_c3_wbd",   wb_dst_o,   5'd3);
      check("int_c3_busy",  busy_o,     32'h0000_0008);
      step(); settle();
      check("int_c4_busy",  busy_o,     32'h0);
      check("int_c4_wbv",   wb_valid_o, 1'b0);

      // Structural conflict: MULDIV dst4 at 0, INT dst5 offered at 4
      do_reset();
      offer(2'd1, 5'd4); settle();
      check("str_c0_ready", in_ready_o, 1'b1);
      step(); in_valid_i = 1'b0;
      step(); step(); step();
      offer(2'd0, 5'd5); settle();
      check("str_c4_ready", in_ready_o, 1'b0);
      step(); settle();
      check("str_c5_ready", in_ready_o, 1'b1);
      check("str_c5_wbv",   wb_valid_o, 1'b1);
      check("str_c5_wbd",   wb_dst_o,   5'd4);
      step(); in_valid_i = 1'b0; settle();
      check("str_c6_wbv",   wb_valid_o, 1'b1);
      check("str_c6_wbd",   wb_dst_o,   5'd5);
      check("str_stall",    stall_cnt_o, 32'd1);

      // FP serialisation
      do_reset();
      offer(2'd1, 5'd6); settle();
      check("fp_c0_ready", in_ready_o, 1'b1);
      step(); offer(2'd3, 5'd7); settle();
      check("fp_c1_ready", in_ready_o, 1'b0);
      for (int c = 2; c <= 6; c++) begin
         step(); settle();
         check($sformatf("fp_drain_c%0d_ready", c), in_ready_o, 1'b0);
         if (c == 5) begin
            check("fp_c5_wbv", wb_valid_o, 1'b1);
            check("fp_c5_wbd", wb_dst_o,   5'd6);
         end
      end
      step(); vex_idle_i = 1'b1; settle();
      check("fp_c7_ready", in_ready_o,  1'b1);
      check("fp_c7_vexv",  vex_valid_o, 1'b1);
      for (int c = 8; c <= 16; c++) begin
         step(); offer(2'd0, 5'd9); settle();
         check($sformatf("fp_wait_c%0d_ready", c), in_ready_o, 1'b0);
      end
      check("fp_wait_busy", busy_o,     32'h0000_0080);
      check("fp_wait_wbv",  wb_valid_o, 1'b0);
      step(); fp_done_i = 1'b1; settle();
      check("fp_done_wbv",   wb_valid_o, 1'b1);
      check("fp_done_wbd",   wb_dst_o,   5'd7);
      check("fp_done_ready", in_ready_o, 1'b0);
      step(); fp_done_i = 1'b0; settle();
      check("fp_c18_busy",  busy_o,     32'h0);
      check("fp_c18_ready", in_ready_o, 1'b1);
      step(); in_valid_i = 1'b0; settle();
      check("fp_c19_wbv", wb_valid_o, 1'b1);
      check("fp_c19_wbd", wb_dst_o,   5'd9);
      step(); fp_done_i = 1'b1; settle();
      check("fp_stray_done_wbv", wb_valid_o, 1'b0);
      fp_done_i = 1'b0;

      // RAW on src1 against an in-flight MULDIV
      do_reset();
      offer(2'd1, 5'd8); settle();
      check("raw_c0_ready", in_ready_o, 1'b1);
      for (int c = 1; c <= 6; c++) begin
         step();
         in_valid_i   = (c <= RAW_ISSUE_CYCLE);
         in_class_i   = 2'd0;
         in_dst_i     = 5'd10;
         in_src1_i    = 5'd8;
         in_src_use_i = 2'b01;
         settle();
         check($sformatf("raw_c%0d_ready", c), in_ready_o, (c == RAW_ISSUE_CYCLE));
      end
      in_valid_i = 1'b0;

      // Reset in FP_WAIT
      do_reset();
      vex_idle_i = 1'b1;
      offer(2'd3, 5'd11); settle();
      check("rfp_c0_ready", in_ready_o, 1'b0);
      step(); settle();
      check("rfp_c1_ready", in_ready_o, 1'b1);
      step(); in_valid_i = 1'b0; settle();
      check("rfp_wait_busy", busy_o, 32'h0000_0800);
      rst_n     = 1'b0;
      fp_done_i = 1'b1;
      settle();
      check("rfp_rst_busy",  busy_o,      32'h0);
      check("rfp_rst_wbv",   wb_valid_o,  1'b0);
      check("rfp_rst_stall", stall_cnt_o, 32'h0);
      step();
      rst_n     = 1'b1;
      fp_done_i = 1'b0;
      offer(2'd0, 5'd12); settle();
      check("rfp_post_ready", in_ready_o, 1'b1);
      step(); in_valid_i = 1'b0; settle();
      check("rfp_post_wbv", wb_valid_o, 1'b1);
      check("rfp_post_wbd", wb_dst_o,   5'd12);

      // Stall counter saturation
      do_reset();
      vex_ready_i = 1'b0;
      offer(2'd0, 5'd1); settle();
      check("sat_ready", in_ready_o, 1'b0);
      step(); settle();
      check("sat_first", stall_cnt_o, 32'd1);
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      step();
      release dut.stall_cnt_q;
      repeat (3) step();
      settle();
      check("sat_hold", stall_cnt_o, 32'hFFFF_FFFF);
      in_valid_i = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
